// File: rtl/block_memory_responder.sv
// Block-addressed main-memory responder for the cache refill/writeback port.
// Each request occupies the responder for a fixed LATENCY, answered through BUSYWAIT.
module block_memory_responder #(
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter int unsigned BLOCK_WIDTH = 128,
  parameter int unsigned LATENCY     = 5,
  parameter logic [15:0] COUNT_INIT  = '0
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   READ,
  input  logic                   WRITE,
  input  logic [ADDR_WIDTH-1:0]  ADDRESS,
  input  logic [BLOCK_WIDTH-1:0] WRITEDATA,
  output logic [BLOCK_WIDTH-1:0] READDATA,
  output logic                   BUSYWAIT,
  output logic                   CONFLICT,
  output logic [15:0]            ACCESS_COUNT
);

  localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [7:0]  CNT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [BLOCK_WIDTH-1:0] data_q, data_d;
  logic                   op_wr_q, op_wr_d;
  logic [BLOCK_WIDTH-1:0] readdata_q, readdata_d;
  logic                   conflict_q, conflict_d;
  logic [15:0]            count_q, count_d;
  logic                   commit_wr;
  logic [BLOCK_WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    op_wr_d    = op_wr_q;
    readdata_d = readdata_q;
    conflict_d = 1'b0;
    count_d    = count_q;
    commit_wr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (READ | WRITE) begin
          addr_d     = ADDRESS;
          data_d     = WRITEDATA;
          op_wr_d    = WRITE;
          cnt_d      = CNT_LOAD;
          conflict_d = READ & WRITE;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          if (op_wr_q) begin
            commit_wr = 1'b1;
          end else begin
            readdata_d = mem_q[addr_q];
          end
          if (count_q != '1) begin
            count_d = count_q + 16'd1;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      op_wr_q    <= 1'b0;
      readdata_q <= '0;
      conflict_q <= 1'b0;
      count_q    <= COUNT_INIT;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      op_wr_q    <= op_wr_d;
      readdata_q <= readdata_d;
      conflict_q <= conflict_d;
      count_q    <= count_d;
    end
  end

  // Storage is cleared on reset so an aborted write leaves no trace.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (commit_wr) begin
      mem_q[addr_q] <= data_q;
    end
  end

  // Held low during reset even if a request is still asserted.
  assign BUSYWAIT     = RESET & ((state_q == BUSY) | ((state_q == IDLE) & (READ | WRITE)));
  assign READDATA     = readdata_q;
  assign CONFLICT     = conflict_q;
  assign ACCESS_COUNT = count_q;

endmodule

// File: tb/tb_block_memory_responder.sv
// Bench for block_memory_responder: a LATENCY=5 instance and a LATENCY=1/ADDR_WIDTH=2 instance.
module tb_block_memory_responder;

  localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] D2 = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
  localparam logic [127:0] D3 = 128'h5A5A_A5A5_0F0F_F0F0_1234_5678_9ABC_DEF0;
  localparam logic [127:0] DA = {8{16'hAAAA}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         rd0 = 1'b0, wr0 = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
  logic [5:0]   addr = '0;
  logic [127:0] wdata = '0;
  logic [127:0] rdata0, rdata1;
  logic         busy0, busy1, conf0, conf1;
  logic [15:0]  cnt0, cnt1;

  block_memory_responder #(.ADDR_WIDTH(6), .BLOCK_WIDTH(128), .LATENCY(5)) u_dut0 (
    .CLK(clk), .RESET(rst_n), .READ(rd0), .WRITE(wr0), .ADDRESS(addr), .WRITEDATA(wdata),
    .READDATA(rdata0), .BUSYWAIT(busy0), .CONFLICT(conf0), .ACCESS_COUNT(cnt0));

  block_memory_responder #(.ADDR_WIDTH(2), .BLOCK_WIDTH(128), .LATENCY(1), .COUNT_INIT(16'hFFFD)) u_dut1 (
    .CLK(clk), .RESET(rst_n), .READ(rd1), .WRITE(wr1), .ADDRESS(addr[1:0]), .WRITEDATA(wdata),
    .READDATA(rdata1), .BUSYWAIT(busy1), .CONFLICT(conf1), .ACCESS_COUNT(cnt1));

  logic         sel = 1'b0;
  logic         busy_s, conf_s;
  logic [127:0] rdata_s;
  logic [15:0]  cnt_s;
  assign busy_s  = sel ? busy1 : busy0;
  assign conf_s  = sel ? conf1 : conf0;
  assign rdata_s = sel ? rdata1 : rdata0;
  assign cnt_s   = sel ? cnt1 : cnt0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference memory: plain arrays indexed by block number, one per instance.
  logic [127:0] m0 [64];
  logic [127:0] m1 [4];
  logic [127:0] mr0, mr1;
  logic [15:0]  mc0, mc1;

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m0[i] = '0;
    for (int i = 0; i < 4; i++) m1[i] = '0;
    mr0 = '0; mr1 = '0; mc0 = 16'h0000; mc1 = 16'hFFFD;
  endtask

  task automatic model_op(input bit s, input bit rd, input bit wr, input logic [5:0] a, input logic [127:0] d);
    if (s) begin
      if (wr) m1[a % 4] = d; else if (rd) mr1 = m1[a % 4];
      if (mc1 != 16'hFFFF) mc1 = mc1 + 1;
    end else begin
      if (wr) m0[a] = d; else if (rd) mr0 = m0[a];
      if (mc0 != 16'hFFFF) mc0 = mc0 + 1;
    end
  endtask

  // Called at posedge+1 with the selected instance idle; returns cycle of the accepting edge.
  task automatic txn(input bit s, input bit rd, input bit wr, input logic [5:0] a, input logic [127:0] d,
                     input bit scr, input logic [127:0] exp_rd, input logic [15:0] exp_cnt,
                     output int unsigned start);
    int unsigned lat, n, cf;
    lat = s ? 1 : 5;
    n = 0; cf = 0; start = 0;
    sel = s; addr = a; wdata = d;
    if (s) begin rd1 = rd; wr1 = wr; end else begin rd0 = rd; wr0 = wr; end
    #1;
    chk("busy_rise", busy_s, 1);
    while (busy_s && n < 64) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) start = cyc;
      if (conf_s) cf++;
      if (n == 1 && scr) begin addr = a + 6'd4; wdata = ~d; end
    end
    chk("busy_cycles", n, lat + 1);
    chk("conflict_pulses", cf, (rd && wr) ? 1 : 0);
    chk("readdata", rdata_s, exp_rd);
    chk("access_count", cnt_s, exp_cnt);
    rd0 = 0; wr0 = 0; rd1 = 0; wr1 = 0;
    @(posedge clk); #1;
    chk("idle_after_done", busy_s, 0);
  endtask

  typedef struct {
    bit           s, rd, wr, scr;
    logic [5:0]   a;
    logic [127:0] d;
    logic [127:0] exp_rd;
    logic [15:0]  exp_cnt;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned st, prev;
    tbl[0]  = '{0, 0, 1, 0, 6'd5, D1,            '0,  16'd1};
    tbl[1]  = '{0, 1, 0, 0, 6'd5, D3,            D1,  16'd2};
    tbl[2]  = '{0, 1, 0, 1, 6'd5, D3,            D1,  16'd3};
    tbl[3]  = '{0, 1, 1, 0, 6'd7, 128'h1,        D1,  16'd4};
    tbl[4]  = '{0, 1, 0, 0, 6'd7, D3,            128'h1, 16'd5};
    tbl[5]  = '{0, 1, 0, 0, 6'd9, D3,            '0,  16'd6};
    tbl[6]  = '{0, 1, 0, 0, 6'd5, D3,            D1,  16'd7};
    tbl[7]  = '{1, 0, 1, 0, 6'd3, D2,            '0,  16'hFFFE};
    tbl[8]  = '{1, 1, 0, 0, 6'd3, D3,            D2,  16'hFFFF};
    tbl[9]  = '{1, 1, 0, 0, 6'd7, D3,            D2,  16'hFFFF};
    tbl[10] = '{1, 0, 1, 0, 6'd4, D3,            D2,  16'hFFFF};
    tbl[11] = '{1, 1, 0, 0, 6'd0, D1,            D3,  16'hFFFF};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_readdata", rdata0, '0);
    chk("rst_busywait", busy0, 0);
    chk("rst_conflict", conf0, 0);
    chk("rst_count0", cnt0, 16'h0000);
    chk("rst_count1", cnt1, 16'hFFFD);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write aborted by reset two cycles into BUSY, then read back.
    sel = 0; addr = 6'd3; wdata = DA; wr0 = 1;
    #1;
    chk("abort_busy_rise", busy0, 1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy_fall", busy0, 0);
    chk("abort_count", cnt0, 16'h0000);
    wr0 = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn(0, 1, 0, 6'd3, '0, 0, '0, 16'd1, st);

    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;

    prev = 0;
    for (int i = 0; i < 12; i++) begin
      txn(tbl[i].s, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].scr,
          tbl[i].exp_rd, tbl[i].exp_cnt, st);
      model_op(tbl[i].s, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d);
      if (i > 0 && tbl[i].s == tbl[i-1].s)
        chk("b2b_spacing", st - prev, tbl[i].s ? 3 : 7);
      prev = st;
    end

    for (int k = 0; k < 40; k++) begin
      bit           s, rd, wr, scr;
      int unsigned  op;
      logic [5:0]   a;
      logic [127:0] d;
      s   = 1'($urandom_range(0, 1));
      op  = $urandom_range(0, 3);
      rd  = (op != 1);
      wr  = (op == 1 || op == 2);
      a   = 6'($urandom_range(0, 7));
      d   = {$urandom, $urandom, $urandom, $urandom};
      scr = 1'($urandom_range(0, 1));
      model_op(s, rd, wr, a, d);
      txn(s, rd, wr, a, d, scr, s ? mr1 : mr0, s ? mc1 : mc0, st);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/block_memory_responder.md
Name: block_memory_responder

Overview:
- Main-memory responder (target) for the cache's block refill/writeback port; the cache initiates READ/WRITE requests and this block answers them.
- It holds a block-addressed storage array and models a fixed access latency, using a BUSYWAIT handshake.
- It is instantiated beside the cache in the processor top and driven by the same CLK/RESET as the cpu.

Parameters:
- ADDR_WIDTH, 6, block-index width; the array holds 2^ADDR_WIDTH blocks.
- BLOCK_WIDTH, 128, bits per block (four 32-bit words).
- LATENCY, 5, cycles spent in BUSY per access; legal range is 1 to 255.

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- RESET  input  1  asynchronous, active-low reset.
- READ  input  1  block read request; held by the initiator until BUSYWAIT falls.
- WRITE  input  1  block write request; same holding rule as READ.
- ADDRESS  input  ADDR_WIDTH  block index of the request.
- WRITEDATA  input  BLOCK_WIDTH  block to be written.
- READDATA  output  BLOCK_WIDTH  block returned by a read; registered.
- BUSYWAIT  output  1  high while a request is being serviced.
- CONFLICT  output  1  one-cycle pulse when READ and WRITE were both sampled high together.
- ACCESS_COUNT  output  16  completed transactions, saturating at 16'hFFFF.

Behaviour:
- Reset (RESET=0, asynchronous):
  - state=IDLE; READDATA=0; CONFLICT=0; ACCESS_COUNT=0.
  - Internal latency counter=0; latched address and data=0; every array entry cleared to 0.
  - Any transaction in flight is aborted: a pending write is not committed.
- States: IDLE, BUSY, DONE.
- BUSYWAIT (combinational) = (state==BUSY) | (state==IDLE & (READ|WRITE)).
  - It therefore rises in the same cycle a request first appears.
- IDLE:
  - At a rising edge with READ|WRITE=1: latch ADDRESS, WRITEDATA and the operation; load counter with LATENCY-1; go to BUSY.
  - If READ and WRITE are both 1: the write takes priority, CONFLICT=1 for that one cycle, and the read is dropped.
  - Otherwise remain in IDLE.
- BUSY:
  - Counter decrements each edge.
  - At the edge where the counter equals 0:
    - Write: commit the latched data to array[latched address]; READDATA is unchanged.
    - Read: READDATA <= array[latched address].
    - ACCESS_COUNT increments unless already 16'hFFFF.
    - Go to DONE.
  - Changes on ADDRESS, WRITEDATA, READ or WRITE during BUSY are ignored.
- DONE:
  - BUSYWAIT=0 and READDATA is valid; the initiator samples it and drops its request.
  - READ/WRITE are ignored in this state.
  - Unconditionally go to IDLE at the next edge.
- Timing, with the request sampled at edge N:
  - BUSYWAIT is high from request assertion through the cycle before edge N+LATENCY.
  - Data is committed or READDATA updated at edge N+LATENCY.
  - The earliest next request is sampled at edge N+LATENCY+2.
  - Per-access occupancy is LATENCY+2 cycles.
- Request still held in IDLE after DONE: it is treated as a new transaction. The initiator must drop its request during DONE.
- READDATA holds its last read value until the next read completes or reset occurs.
- ADDRESS indexes the array modulo 2^ADDR_WIDTH; there is no out-of-range case.

Test Plan:
- Reset mid-BUSY:
  - Stimulus: issue WRITE to addr 6'd3 with 128'hAAAA...; pull RESET low 2 cycles into BUSY; release; READ addr 3.
  - Required response: BUSYWAIT falls immediately on reset, ACCESS_COUNT=0, and the read returns 0 (write aborted).
- Write then read:
  - Stimulus: WRITE addr 6'd5 with data 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, held until BUSYWAIT falls; then READ addr 5.
  - Required response: BUSYWAIT is high exactly 6 cycles per access (LATENCY+1 edges), READDATA equals the written value in DONE, ACCESS_COUNT=2.
- Input changes during BUSY:
  - Stimulus: READ addr 5; change ADDRESS to 6'd9 and WRITEDATA while BUSY.
  - Required response: READDATA still returns the addr-5 block; addr 9 remains 0.
- Simultaneous READ and WRITE:
  - Stimulus: assert READ and WRITE together on addr 6'd7 with data 128'h1.
  - Required response: CONFLICT pulses one cycle, addr 7 becomes 128'h1, and READDATA is unchanged.
- Back-to-back transactions:
  - Stimulus: after DONE, assert the next READ in the first IDLE cycle (edge N+7).
  - Required response: it is accepted; consecutive accesses start 7 cycles apart (LATENCY+2 with LATENCY=5).
- Minimum latency and wrap-around:
  - Stimulus: instantiate with LATENCY=1 and ADDR_WIDTH=2; write and read addr 2'd3.
  - Required response: BUSY lasts one cycle and the data round-trips correctly.
  - Stimulus: preset ACCESS_COUNT near saturation and run 3 accesses.
  - Required response: ACCESS_COUNT saturates at 16'hFFFF.
